// File: rtl/shaper_readout_buffer.sv
// Shaper readout stage: scales and BCID-tags samples, captures one orbit-aligned window into a FWFT FIFO.
// Define READOUT_SATURATE_EN to clip the scaled sample to OUT_BITS; otherwise the low OUT_BITS are kept (wrap).
module shaper_readout_buffer #(
   parameter int SAMPLE_BITS = 30,
   parameter int SHIFT       = 14,
   parameter int OUT_BITS    = 16,
   parameter int BUNCH_POS   = 3564,
   parameter int BCID_BITS   = 12,
   parameter int FIFO_AW     = 9,
   parameter int CAPTURE_LEN = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic signed [SAMPLE_BITS-1:0]     sample_in,
   input  logic                              hit_in,
   input  logic                              arm,
   input  logic                              rd_ready,
   output logic                              rd_valid,
   output logic [BCID_BITS+OUT_BITS:0]       rd_data,
   output logic                              busy,
   output logic                              done,
   output logic                              overflow,
   output logic [FIFO_AW:0]                  fill_level
);

   // state      | meaning
   // S_IDLE     | waiting for arm
   // S_WAIT     | armed, waiting for S1 BCID to reach the last bunch of the orbit
   // S_CAPTURE  | one write attempt per clk, cnt_q counts down remaining attempts
   // S_DONE     | window complete, waiting for the FIFO to drain

   localparam int DW    = BCID_BITS + 1 + OUT_BITS;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [BCID_BITS-1:0] BCID_LAST = BCID_BITS'(BUNCH_POS - 1);
   localparam logic [15:0] LEN_M1 = 16'(CAPTURE_LEN - 1);
   localparam logic signed [SAMPLE_BITS-1:0] OUT_MAX = SAMPLE_BITS'(2**(OUT_BITS-1) - 1);
   localparam logic signed [SAMPLE_BITS-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

   state_t                         state_q;
   logic                           busy_q, done_q, overflow_q;
   logic [15:0]                    cnt_q;
   logic [BCID_BITS-1:0]           bcid_q, bcid_s1_q;
   logic signed [SAMPLE_BITS-1:0]  sample_s1_q;
   logic                           hit_s1_q;
   logic [DW-1:0]                  mem_q [DEPTH];
   logic [FIFO_AW:0]               wr_ptr_q, rd_ptr_q;

   logic signed [SAMPLE_BITS-1:0]  scaled;
   logic [OUT_BITS-1:0]            narrow;
   logic [DW-1:0]                  wr_word;
   logic                           empty, full, pop, wr_attempt, push;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcid_q      <= '0;
         bcid_s1_q   <= '0;
         sample_s1_q <= '0;
         hit_s1_q    <= 1'b0;
      end else begin
         bcid_q      <= (bcid_q == BCID_LAST) ? '0 : bcid_q + 1'b1;
         bcid_s1_q   <= bcid_q;
         sample_s1_q <= sample_in;
         hit_s1_q    <= hit_in;
      end
   end

   assign scaled = sample_s1_q >>> SHIFT;

   always_comb begin
      narrow = scaled[OUT_BITS-1:0];
`ifdef READOUT_SATURATE_EN
      if (scaled > OUT_MAX)
         narrow = OUT_MAX[OUT_BITS-1:0];
      else if (scaled < OUT_MIN)
         narrow = OUT_MIN[OUT_BITS-1:0];
`endif
   end

   assign wr_word    = {bcid_s1_q, hit_s1_q, narrow};
   assign fill_level = wr_ptr_q - rd_ptr_q;
   assign empty      = (fill_level == '0);
   assign full       = fill_level[FIFO_AW];
   assign rd_valid   = !empty;
   assign pop        = rd_valid && rd_ready;
   assign wr_attempt = (state_q == S_CAPTURE);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
   assign push       = wr_attempt && (!full || pop);
   assign rd_data    = rd_valid ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_q    <= S_WAIT;
                  busy_q     <= 1'b1;
                  overflow_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (bcid_s1_q == BCID_LAST) begin
                  state_q <= S_CAPTURE;
                  cnt_q   <= LEN_M1;
               end
            end
            S_CAPTURE: begin
               if (full && !pop)
                  overflow_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (empty) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule
